// File: rtl/spi_buffer_ctrl_pkg.sv
// Shared types and constants for the SPI buffer sequencer: state encoding,
// forced transmit fill bytes and default widths.
package pkg_spi;

    localparam int ADDR_W = 10;
    localparam int DATA_W = 8;
    localparam int CNT_W  = 10;

    localparam logic [7:0] SPI_FILL_ONES  = 8'hFF;
    localparam logic [7:0] SPI_FILL_ZEROS = 8'h00;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_LOAD,
        ST_START,
        ST_WAIT,
        ST_STORE,
        ST_FINISH
    } spi_ctrl_state_e;

endpackage

// File: rtl/spi_buffer_ctrl_xfer_counter.sv
// Burst byte counter: clears and latches the burst length at start, counts
// completed bytes and flags the byte that ends the burst.
module spi_xfer_counter
    import pkg_spi::*;
#(
    parameter int CNT_W = pkg_spi::CNT_W
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             clear,
    input  logic [CNT_W-1:0] target,
    input  logic             incr,
    output logic [CNT_W-1:0] count,
    output logic             last
);

    localparam logic [CNT_W-1:0] ONE = CNT_W'(1);

    logic [CNT_W-1:0] count_reg;
    logic [CNT_W-1:0] target_reg;

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            count_reg  <= '0;
            target_reg <= '0;
        end else if (clear) begin
            count_reg  <= '0;
            target_reg <= target;
        end else if (incr) begin
            count_reg  <= count_reg + ONE;
        end
    end

    // Evaluated before the increment: true while the final byte is being retired.
    assign last  = ((count_reg + ONE) == target_reg);
    assign count = count_reg;

endmodule

// File: rtl/spi_buffer_ctrl.sv
// SPI buffer sequencer: owns the buffer port during a burst, feeds bytes to the
// shifter and, with SPI_CTRL_RX_STORE_EN defined, writes received bytes back.
module spi_buffer_ctrl
    import pkg_spi::*;
#(
    parameter int ADDR_W = pkg_spi::ADDR_W,
    parameter int DATA_W = pkg_spi::DATA_W,
    parameter int CNT_W  = pkg_spi::CNT_W
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              send_i,
    input  logic [CNT_W-1:0]  n_tx_i,
    input  logic              all_ones_i,
    input  logic              all_zeros_i,
    output logic              hold_ctrl_o,
    output logic [ADDR_W-1:0] buf_addr_o,
    output logic              buf_wr_o,
    output logic [DATA_W-1:0] buf_wdata_o,
    input  logic [DATA_W-1:0] buf_rdata_i,
    output logic              shift_start_o,
    output logic [DATA_W-1:0] shift_tx_o,
    input  logic              shift_done_i,
    input  logic [DATA_W-1:0] shift_rx_i,
    output logic              cs_n_o,
    output logic              busy_o,
    output logic              done_o,
    output logic [CNT_W-1:0]  tx_count_o
);

    spi_ctrl_state_e state_reg, state_next;

    logic              send_reg;
    logic              ones_reg;
    logic              zeros_reg;
    logic [DATA_W-1:0] tx_reg;
    logic              send_rise;
    logic              count_clear;
    logic              count_incr;
    logic              count_last;
    logic [CNT_W-1:0]  count;
    logic [DATA_W-1:0] fill_ones;
    logic [DATA_W-1:0] fill_zeros;

    // Fill patterns stretched to DATA_W by repeating the byte constants.
    generate
        for (genvar gi = 0; gi < DATA_W; gi++) begin : g_fill
            assign fill_ones[gi]  = SPI_FILL_ONES[gi % 8];
            assign fill_zeros[gi] = SPI_FILL_ZEROS[gi % 8];
        end
    endgenerate

    assign send_rise = send_i & ~send_reg;

    spi_xfer_counter #(
        .CNT_W (CNT_W)
    ) u_counter (
        .clk_i  (clk_i),
        .rst_i  (rst_i),
        .clear  (count_clear),
        .target (n_tx_i),
        .incr   (count_incr),
        .count  (count),
        .last   (count_last)
    );

    always_comb begin
        state_next  = state_reg;
        count_clear = 1'b0;
        count_incr  = 1'b0;
        case (state_reg)
            ST_IDLE: begin
                if (send_rise) begin
                    count_clear = 1'b1;
                    state_next  = (n_tx_i == '0) ? ST_FINISH : ST_LOAD;
                end
            end
            ST_LOAD:  state_next = ST_START;
            ST_START: state_next = ST_WAIT;
            ST_WAIT: begin
                if (shift_done_i) begin
`ifdef SPI_CTRL_RX_STORE_EN
                    state_next = ST_STORE;
`else
                    count_incr = 1'b1;
                    state_next = count_last ? ST_FINISH : ST_LOAD;
`endif
                end
            end
            ST_STORE: begin
                count_incr = 1'b1;
                state_next = count_last ? ST_FINISH : ST_LOAD;
            end
            ST_FINISH: state_next = ST_IDLE;
            default:   state_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            state_reg <= ST_IDLE;
            send_reg  <= 1'b0;
            ones_reg  <= 1'b0;
            zeros_reg <= 1'b0;
            tx_reg    <= '0;
        end else begin
            state_reg <= state_next;
            send_reg  <= send_i;
            if (count_clear) begin
                ones_reg  <= all_ones_i;
                zeros_reg <= all_zeros_i;
            end
            if (state_reg == ST_LOAD) begin
                tx_reg <= ones_reg  ? fill_ones  :
                          zeros_reg ? fill_zeros : buf_rdata_i;
            end
        end
    end

`ifdef SPI_CTRL_RX_STORE_EN
    logic [DATA_W-1:0] rx_reg;

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            rx_reg <= '0;
        end else if (state_reg == ST_WAIT && shift_done_i) begin
            rx_reg <= shift_rx_i;
        end
    end

    assign buf_wr_o    = (state_reg == ST_STORE);
    assign buf_wdata_o = rx_reg;
`else
    logic unused_rx;
    assign unused_rx   = ^shift_rx_i;
    assign buf_wr_o    = 1'b0;
    assign buf_wdata_o = '0;
`endif

    assign busy_o        = (state_reg != ST_IDLE);
    assign hold_ctrl_o   = busy_o;
    assign buf_addr_o    = count[ADDR_W-1:0];
    assign shift_start_o = (state_reg == ST_START);
    assign shift_tx_o    = tx_reg;
    // Select is active only in the per-byte states; zero-length bursts never drop it.
    assign cs_n_o        = !(state_reg == ST_LOAD  || state_reg == ST_START ||
                             state_reg == ST_WAIT  || state_reg == ST_STORE);
    assign done_o        = (state_reg == ST_FINISH);
    assign tx_count_o    = count;

endmodule

// File: tb/tb_spi_buffer_ctrl.sv
// Randomised bench for spi_buffer_ctrl: buffer memory, echoing shifter and a
// per-burst reference of transmitted bytes and final buffer contents.
module tb_spi_buffer_ctrl;

    localparam int AW = 10;
    localparam int DW = 8;
    localparam int CW = 10;

    logic          clk_i = 1'b0;
    logic          rst_i;
    logic          send_i;
    logic [CW-1:0] n_tx_i;
    logic          all_ones_i;
    logic          all_zeros_i;
    logic          hold_ctrl_o;
    logic [AW-1:0] buf_addr_o;
    logic          buf_wr_o;
    logic [DW-1:0] buf_wdata_o;
    logic [DW-1:0] buf_rdata_i;
    logic          shift_start_o;
    logic [DW-1:0] shift_tx_o;
    logic          shift_done_i;
    logic [DW-1:0] shift_rx_i;
    logic          cs_n_o;
    logic          busy_o;
    logic          done_o;
    logic [CW-1:0] tx_count_o;

    logic [7:0] mem [0:1023];

    int checks = 0;
    int errors = 0;

`ifdef SPI_CTRL_RX_STORE_EN
    localparam bit STORE_EN = 1'b1;
`else
    localparam bit STORE_EN = 1'b0;
`endif

    always #5 clk_i = ~clk_i;

    assign buf_rdata_i = mem[buf_addr_o];

    spi_buffer_ctrl dut (
        .clk_i         (clk_i),
        .rst_i         (rst_i),
        .send_i        (send_i),
        .n_tx_i        (n_tx_i),
        .all_ones_i    (all_ones_i),
        .all_zeros_i   (all_zeros_i),
        .hold_ctrl_o   (hold_ctrl_o),
        .buf_addr_o    (buf_addr_o),
        .buf_wr_o      (buf_wr_o),
        .buf_wdata_o   (buf_wdata_o),
        .buf_rdata_i   (buf_rdata_i),
        .shift_start_o (shift_start_o),
        .shift_tx_o    (shift_tx_o),
        .shift_done_i  (shift_done_i),
        .shift_rx_i    (shift_rx_i),
        .cs_n_o        (cs_n_o),
        .busy_o        (busy_o),
        .done_o        (done_o),
        .tx_count_o    (tx_count_o)
    );

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    // One burst: the reference is the byte list the controller must transmit and,
    // with write-back, the buffer image after every byte is echoed inverted.
    task automatic run_burst(input int n, input bit ones, input bit zeros,
                             input int dmax, input bit toggle_send);
        logic [7:0] pre [0:1023];
        logic [7:0] exp_tx [$];
        logic [7:0] cur_tx = 8'h00;
        logic [7:0] exp_b;
        int starts = 0, writes = 0, cs_bad = 0, stable_bad = 0, tx_bad = 0;
        int wr_lat_bad = 0, extra = 0, mism = 0, done_cyc = -1, pending = -1;
        bit prev_done;
        bit fin = 1'b0;
        int budget = n * (dmax + 4) + 20;

        for (int i = 0; i < 1024; i++) pre[i] = mem[i];
        for (int i = 0; i < n; i++)
            exp_tx.push_back(ones ? 8'hFF : zeros ? 8'h00 : pre[i]);

        send_i      = 1'b0;
        n_tx_i      = CW'(n);
        all_ones_i  = ones;
        all_zeros_i = zeros;
        tick();
        send_i = 1'b1;
        for (int cyc = 1; cyc <= budget && !fin; cyc++) begin
            tick();
            prev_done    = shift_done_i;
            shift_done_i = 1'b0;
            if (cyc == 1) check_eq("busy_latency", busy_o, 1);
            if (buf_wr_o) begin
                writes++;
                if (!prev_done) wr_lat_bad++;
                mem[buf_addr_o] = buf_wdata_o;
            end
            if (n == 0) begin
                if (cs_n_o !== 1'b1) cs_bad++;
            end else if (busy_o && !done_o && cs_n_o !== 1'b0) begin
                cs_bad++;
            end
            if (shift_start_o) begin
                if (starts >= n || shift_tx_o !== exp_tx[starts]) tx_bad++;
                cur_tx  = shift_tx_o;
                starts++;
                pending = $urandom_range(dmax, 1);
            end else if (pending > 0) begin
                if (shift_tx_o !== cur_tx) stable_bad++;
                pending--;
                if (pending == 0) begin
                    shift_done_i = 1'b1;
                    shift_rx_i   = ~cur_tx;
                    pending      = -1;
                end
            end
            if (toggle_send && cyc == 3) send_i = 1'b0;
            if (toggle_send && cyc == 5) send_i = 1'b1;
            if (done_o) begin
                done_cyc = cyc;
                fin      = 1'b1;
            end
        end
        check_eq("done_seen", fin, 1);
        // Idle aftermath: a stray shifter pulse and a still-high send must not start anything.
        for (int k = 0; k < 6; k++) begin
            tick();
            shift_done_i = (k == 1);
            if (k > 0 && (busy_o || shift_start_o || done_o || buf_wr_o)) extra++;
        end
        shift_done_i = 1'b0;
        check_eq("idle_quiet", extra, 0);
        check_eq("idle_count", tx_count_o, n);
        check_eq("start_count", starts, n);
        check_eq("tx_bytes", tx_bad, 0);
        check_eq("tx_stable", stable_bad, 0);
        check_eq("cs_n_level", cs_bad, 0);
        check_eq("write_count", writes, STORE_EN ? n : 0);
        check_eq("write_latency", wr_lat_bad, 0);
        if (n == 0) check_eq("zero_done_cycle", done_cyc, 1);
        for (int i = 0; i < 1024; i++) begin
            exp_b = (STORE_EN && i < n) ? ~exp_tx[i] : pre[i];
            if (mem[i] !== exp_b) mism++;
        end
        check_eq("buffer_image", mism, 0);
        send_i = 1'b0;
        $display("burst n=%0d ones=%0b zeros=%0b toggle=%0b starts=%0d writes=%0d done_cycle=%0d",
                 n, ones, zeros, toggle_send, starts, writes, done_cyc);
    endtask

    initial begin
        int st;
        bit hit;
        int late;

        rst_i        = 1'b0;
        send_i       = 1'b0;
        n_tx_i       = '0;
        all_ones_i   = 1'b0;
        all_zeros_i  = 1'b0;
        shift_done_i = 1'b0;
        shift_rx_i   = '0;
        for (int i = 0; i < 1024; i++) mem[i] = 8'($urandom);
        repeat (3) tick();
        check_eq("rst_cs_n", cs_n_o, 1);
        check_eq("rst_busy", busy_o, 0);
        check_eq("rst_hold", hold_ctrl_o, 0);
        check_eq("rst_done", done_o, 0);
        check_eq("rst_count", tx_count_o, 0);
        check_eq("rst_start", shift_start_o, 0);
        check_eq("rst_wr", buf_wr_o, 0);
        check_eq("rst_addr", buf_addr_o, 0);
        check_eq("rst_tx", shift_tx_o, 0);
        rst_i = 1'b1;
        repeat (2) tick();

        mem[0] = 8'h11;
        mem[1] = 8'h22;
        mem[2] = 8'h33;
        run_burst(3, 1'b0, 1'b0, 3, 1'b0);
        check_eq("b3_addr0", mem[0], STORE_EN ? 8'hEE : 8'h11);
        check_eq("b3_addr1", mem[1], STORE_EN ? 8'hDD : 8'h22);
        check_eq("b3_addr2", mem[2], STORE_EN ? 8'hCC : 8'h33);
        check_eq("b3_count", tx_count_o, 3);

        run_burst(2, 1'b1, 1'b1, 2, 1'b0);
        run_burst(2, 1'b0, 1'b1, 2, 1'b0);
        run_burst(0, 1'b0, 1'b0, 1, 1'b0);
        run_burst(4, 1'b0, 1'b0, 4, 1'b1);

        for (int r = 0; r < 8; r++) begin
            for (int i = 0; i < 16; i++) mem[i] = 8'($urandom);
            run_burst($urandom_range(9, 1), ($urandom_range(3, 0) == 0),
                      ($urandom_range(3, 0) == 0), 5, ($urandom_range(1, 0) == 1));
        end

        // Reset while waiting on the second of four bytes.
        send_i      = 1'b0;
        n_tx_i      = CW'(4);
        all_ones_i  = 1'b0;
        all_zeros_i = 1'b0;
        tick();
        send_i = 1'b1;
        st  = 0;
        hit = 1'b0;
        for (int c = 0; c < 40 && !hit; c++) begin
            tick();
            shift_done_i = 1'b0;
            if (shift_start_o) begin
                st++;
                tick();
                if (st == 1) begin
                    shift_done_i = 1'b1;
                    shift_rx_i   = 8'h5A;
                end else begin
                    hit = 1'b1;
                end
            end
        end
        check_eq("rst_mid_reached_wait", hit, 1);
        check_eq("rst_mid_busy_before", busy_o, 1);
        rst_i  = 1'b0;
        send_i = 1'b0;
        #2;
        check_eq("rst_mid_cs_n_async", cs_n_o, 1);
        tick();
        check_eq("rst_mid_hold", hold_ctrl_o, 0);
        check_eq("rst_mid_cs_n", cs_n_o, 1);
        check_eq("rst_mid_busy", busy_o, 0);
        check_eq("rst_mid_count", tx_count_o, 0);
        rst_i = 1'b1;
        late  = 0;
        for (int k = 0; k < 8; k++) begin
            tick();
            if (done_o || busy_o) late++;
        end
        check_eq("rst_mid_no_done", late, 0);
        $display("burst n=4 abandoned by reset in byte 2 wait");

        run_burst(3, 1'b0, 1'b0, 2, 1'b0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
